// File: rtl/uart_fifo_bridge.sv
// Byte buffering between the host bus and the uart core: a TX FIFO that feeds the
// uart start_tx/tx_done handshake and an RX FIFO filled from rx_available/rx_clear.
module uart_fifo_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_wr_en,
  input  logic [7:0]    tx_wr_data,
  output logic          tx_full,
  output logic [AW:0]   tx_count,
  input  logic          rx_rd_en,
  output logic [7:0]    rx_rd_data,
  output logic          rx_empty,
  output logic [AW:0]   rx_count,
  output logic          rx_overflow,
  input  logic          overflow_clr,
  output logic          uart_start_tx,
  output logic [7:0]    uart_tx_value,
  input  logic          uart_tx_done,
  input  logic          uart_rx_available,
  input  logic [7:0]    uart_rx_value,
  output logic          uart_rx_clear
);
  localparam int        CW         = AW + 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [1:0] {TX_IDLE, TX_BUSY, TX_RELEASE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_SETTLE, RX_CAPTURE, RX_CLEAR} rx_state_t;

  tx_state_t   tx_state;
  rx_state_t   rx_state;

  logic [7:0]  tx_mem [DEPTH];
  logic [7:0]  rx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;

  logic tx_push, tx_pop, rx_push, rx_pop, rx_space, rx_drop;

  assign tx_full    = (tx_count == FULL_COUNT);
  assign rx_empty   = (rx_count == '0);
  assign rx_rd_data = rx_mem[rx_rptr];

  assign tx_push  = tx_wr_en && !tx_full;
  assign tx_pop   = (tx_state == TX_IDLE) && (tx_count != '0);
  assign rx_pop   = rx_rd_en && !rx_empty;
  // A host pop in the capture cycle frees the slot the incoming byte needs.
  assign rx_space = (rx_count != FULL_COUNT) || rx_pop;
  assign rx_push  = (rx_state == RX_CAPTURE) && rx_space;
  assign rx_drop  = (rx_state == RX_CAPTURE) && !rx_space;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= tx_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state      <= TX_IDLE;
      uart_start_tx <= 1'b0;
      uart_tx_value <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          uart_tx_value <= tx_mem[tx_rptr];
          uart_start_tx <= 1'b1;
          tx_state      <= TX_BUSY;
        end
        TX_BUSY: if (uart_tx_done) begin
          uart_start_tx <= 1'b0;
          tx_state      <= TX_RELEASE;
        end
        TX_RELEASE: if (!uart_tx_done) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr] <= uart_rx_value;
        rx_wptr         <= rx_wptr + AW'(1);
      end
      if (rx_pop) rx_rptr <= rx_rptr + AW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // rx_value is only valid one cycle after rx_available rises, hence RX_SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      uart_rx_clear <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          uart_rx_clear <= 1'b0;
          if (uart_rx_available) rx_state <= RX_SETTLE;
        end
        RX_SETTLE: rx_state <= RX_CAPTURE;
        RX_CAPTURE: begin
          uart_rx_clear <= 1'b1;
          rx_state      <= RX_CLEAR;
        end
        RX_CLEAR: if (!uart_rx_available) begin
          uart_rx_clear <= 1'b0;
          rx_state      <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rx_overflow <= 1'b0;
    else if (rx_drop)      rx_overflow <= 1'b1;
    else if (overflow_clr) rx_overflow <= 1'b0;
  end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: a uart model, a TX scoreboard queue checked by a monitor
// on every start_tx, and an RX reference FIFO checked on every host read.
module tb_uart_fifo_bridge;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk, rst_n;
  logic          tx_wr_en;
  logic [7:0]    tx_wr_data;
  logic          tx_full;
  logic [AW:0]   tx_count;
  logic          rx_rd_en;
  logic [7:0]    rx_rd_data;
  logic          rx_empty;
  logic [AW:0]   rx_count;
  logic          rx_overflow;
  logic          overflow_clr;
  logic          uart_start_tx;
  logic [7:0]    uart_tx_value;
  logic          uart_tx_done;
  logic          uart_rx_available;
  logic [7:0]    uart_rx_value;
  logic          uart_rx_clear;

  uart_fifo_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_count(tx_count),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .overflow_clr(overflow_clr),
    .uart_start_tx(uart_start_tx), .uart_tx_value(uart_tx_value), .uart_tx_done(uart_tx_done),
    .uart_rx_available(uart_rx_available), .uart_rx_value(uart_rx_value),
    .uart_rx_clear(uart_rx_clear)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int         tx_pending    = 0;
  bit         ovf_model     = 0;
  int         tx_done_delay = 20;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // uart TX side model and TX monitor
  initial begin : tx_uart_model
    logic       prev_start;
    logic [7:0] held;
    int         wait_cnt;
    prev_start   = 1'b0;
    held         = '0;
    wait_cnt     = 0;
    uart_tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_start   = 1'b0;
        uart_tx_done = 1'b0;
        wait_cnt     = 0;
        continue;
      end
      if (uart_start_tx && !prev_start) begin
        tx_pending--;
        if (tx_exp_q.size() == 0) check("tx_unexpected_start", 1, 0);
        else check("tx_byte", uart_tx_value, tx_exp_q.pop_front());
        held     = uart_tx_value;
        wait_cnt = tx_done_delay;
      end else if (uart_start_tx) begin
        check("tx_value_stable", uart_tx_value, held);
        if (!uart_tx_done) begin
          if (wait_cnt > 0) wait_cnt--;
          if (wait_cnt == 0) uart_tx_done = 1'b1;
        end
      end else if (uart_tx_done) begin
        uart_tx_done = 1'b0;
      end
      prev_start = uart_start_tx;
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0; overflow_clr = 1'b0;
    uart_rx_available = 1'b0; uart_rx_value = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk);
    check("tx_count", tx_count, tx_pending);
    check("tx_full", tx_full, tx_pending == DEPTH);
    tx_wr_en   = 1'b1;
    tx_wr_data = b;
    if (tx_pending < DEPTH) begin
      tx_pending++;
      tx_exp_q.push_back(b);
    end
  endtask

  task automatic push_idle();
    @(negedge clk);
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || uart_start_tx || uart_tx_done) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tx_drain_timeout", n < 3000, 1);
    check("tx_count_drained", tx_count, 0);
  endtask

  task automatic rx_send(input logic [7:0] b, input bit pop_at_capture, input bit clr_at_capture);
    bit drop;
    int n;
    @(negedge clk); uart_rx_available = 1'b1;
    @(negedge clk); uart_rx_value = b;
    @(negedge clk);
    check("rx_count_before_capture", rx_count, rx_exp_q.size());
    if (pop_at_capture && rx_exp_q.size() != 0) begin
      check("rx_head_at_capture", rx_rd_data, rx_exp_q.pop_front());
      rx_rd_en = 1'b1;
    end
    if (clr_at_capture) overflow_clr = 1'b1;
    drop = (rx_exp_q.size() >= DEPTH);
    if (!drop) rx_exp_q.push_back(b);
    if (drop) ovf_model = 1'b1;
    else if (clr_at_capture) ovf_model = 1'b0;
    @(negedge clk);
    rx_rd_en = 1'b0; overflow_clr = 1'b0;
    check("rx_count_after_capture", rx_count, rx_exp_q.size());
    check("rx_empty_after_capture", rx_empty, rx_exp_q.size() == 0);
    check("rx_overflow", rx_overflow, ovf_model);
    check("rx_clear_raised", uart_rx_clear, 1);
    uart_rx_available = 1'b0;
    n = 0;
    while (uart_rx_clear && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rx_clear_released", uart_rx_clear, 0);
  endtask

  task automatic host_pop();
    @(negedge clk);
    if (rx_exp_q.size() == 0) check("rx_empty_flag", rx_empty, 1);
    else check("rx_rd_data", rx_rd_data, rx_exp_q.pop_front());
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
    check("rx_count_after_pop", rx_count, rx_exp_q.size());
  endtask

  task automatic clear_ovf();
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    ovf_model = 1'b0;
    check("rx_overflow_cleared", rx_overflow, 0);
  endtask

  // stimulus
  initial begin : main
    logic [7:0] b;
    bit         p, c;
    int         n, gap;
    rst_n = 1'b1;
    do_reset();
    check("reset_tx_full", tx_full, 0);
    check("reset_tx_count", tx_count, 0);
    check("reset_rx_empty", rx_empty, 1);
    check("reset_rx_count", rx_count, 0);
    check("reset_rx_rd_data", rx_rd_data, 0);
    check("reset_start_tx", uart_start_tx, 0);
    check("reset_tx_value", uart_tx_value, 0);
    check("reset_rx_clear", uart_rx_clear, 0);
    check("reset_rx_overflow", rx_overflow, 0);

    // single byte, uart done 20 cycles after start
    tx_done_delay = 20;
    push_tx(8'hA5);
    push_idle();
    check("tx1_count_one", tx_count, 1);
    check("tx1_start_low", uart_start_tx, 0);
    @(negedge clk);
    check("tx1_start_high", uart_start_tx, 1);
    check("tx1_value", uart_tx_value, 8'hA5);
    check("tx1_count_zero", tx_count, 0);
    wait_tx_drain();

    // back-to-back burst against a stalled uart
    tx_done_delay = 30;
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44); push_tx(8'h55);
    push_tx(8'h66);
    check("burst_full_after_fifth", tx_full, 1);
    push_idle();
    check("burst_sixth_dropped", tx_count, 4);
    wait_tx_drain();

    // randomized TX traffic, including pushes while full
    for (int i = 0; i < 40; i++) begin
      tx_done_delay = $urandom_range(1, 6);
      b = 8'($urandom_range(0, 255));
      push_tx(b);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        push_idle();
        repeat (gap - 1) @(negedge clk);
      end
    end
    push_idle();
    wait_tx_drain();

    // single received byte
    rx_send(8'h3C, 0, 0);
    check("rx1_data", rx_rd_data, 8'h3C);
    check("rx1_count", rx_count, 1);
    host_pop();
    check("rx1_empty", rx_empty, 1);

    // overflow, clear, and set-beats-clear
    for (int i = 1; i <= 5; i++) rx_send(8'(i), 0, 0);
    check("ovf_set", rx_overflow, 1);
    clear_ovf();
    rx_send(8'h06, 0, 1);
    check("ovf_set_wins", rx_overflow, 1);
    clear_ovf();

    // pop in the capture cycle of a full FIFO makes room
    rx_send(8'h77, 1, 0);
    check("pop_capture_no_ovf", rx_overflow, 0);
    check("pop_capture_count", rx_count, 4);
    repeat (5) host_pop();

    // randomized RX traffic against the reference FIFO
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 5) == 0);
      rx_send(b, p, c);
      n = $urandom_range(0, 2);
      repeat (n) host_pop();
    end
    while (rx_exp_q.size() != 0) host_pop();
    if (ovf_model) clear_ovf();

    // asynchronous reset mid TX_BUSY and mid RX_CLEAR
    tx_done_delay = 200;
    push_tx(8'hC3);
    push_tx(8'h3C);
    push_idle();
    n = 0;
    while (!uart_start_tx && n < 10) begin @(negedge clk); n++; end
    check("rst_test_tx_busy", uart_start_tx, 1);
    uart_rx_available = 1'b1;
    @(negedge clk); uart_rx_value = 8'h99;
    n = 0;
    while (!uart_rx_clear && n < 10) begin @(negedge clk); n++; end
    check("rst_test_rx_clear", uart_rx_clear, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_start_tx", uart_start_tx, 0);
    check("async_rst_rx_clear", uart_rx_clear, 0);
    check("async_rst_tx_count", tx_count, 0);
    check("async_rst_rx_count", rx_count, 0);
    check("async_rst_rx_empty", rx_empty, 1);
    tx_exp_q.delete();
    rx_exp_q.delete();
    tx_pending = 0;
    ovf_model  = 1'b0;
    do_reset();

    // traffic after reset
    tx_done_delay = 3;
    push_tx(8'h5A);
    push_idle();
    wait_tx_drain();
    rx_send(8'hE7, 0, 0);
    host_pop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
